vram_line_fetcher: RTL and testbench

- Burst-read engine directly upstream of the VRAM arbiter. It drives one read-only arbiter port (strobe/addr/ack/rddata) and streams a run of consecutive 32-bit VRAM words into an internal FIFO.
- A valid/ready stream presents the FIFO contents to the scanline renderer.
- It turns "fetch N words from base address B" into the one-request-per-arbiter-slot protocol the VRAM interface expects.

---
 rtl/vram_line_fetcher.sv | 135 +++++++++++++
 tb/tb_vram_line_fetcher.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_line_fetcher.sv
// Burst-read engine: fetches a run of consecutive VRAM words through one arbiter port into a FWFT FIFO.
// Optional stall counter output enabled by defining VRAM_LINE_FETCHER_STATS_EN.
module vram_line_fetcher #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [14:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic [14:0]      vram_addr,
    output logic             vram_strobe,
    input  logic             vram_ack,
    input  logic [31:0]      vram_rddata,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef VRAM_LINE_FETCHER_STATS_EN
    ,
    output logic [15:0]      stall_cycles
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, LAST} state_t;

    state_t           state, state_nx;
    logic [14:0]      addr_q, addr_nx;
    logic [CNT_W-1:0] remaining, remaining_nx;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fifo_count;
    logic             room;
    logic             accept;
    logic             rd_en;

    // Strobe is derived from registered state only; while it waits for ack the FIFO
    // can only drain, so strobe and address cannot change until the ack arrives.
    assign room        = (fifo_count < FULL_CNT);
    assign vram_strobe = (state == REQ) && (remaining != '0) && room;
    assign vram_addr   = addr_q;
    assign accept      = vram_strobe && vram_ack;
    assign busy        = (state == REQ);
    assign done        = (state == LAST);

    assign out_valid   = (fifo_count != '0);
    assign rd_en       = out_valid && out_ready;
    assign out_data    = out_valid ? mem[rd_ptr] : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nx;
            addr_q    <= addr_nx;
            remaining <= remaining_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        addr_nx      = addr_q;
        remaining_nx = remaining;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_nx      = base_addr;
                    remaining_nx = word_count;
                    state_nx     = (word_count == '0) ? LAST : REQ;
                end
            end
            REQ: begin
                if (accept) begin
                    addr_nx      = addr_q + 15'd1;
                    remaining_nx = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_nx = LAST;
                    end
                end
            end
            LAST:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Storage has no reset; out_data is gated by out_valid so stale words never show.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= vram_rddata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, rd_en})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef VRAM_LINE_FETCHER_STATS_EN
    // Counts cycles where a request is due but held back by a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cycles <= '0;
        end else if ((state == REQ) && (remaining != '0) && !room &&
                     (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_line_fetcher.sv
// Directed self-checking bench for vram_line_fetcher with a 4-cycle arbiter model.
// Also checks stall_cycles when built with VRAM_LINE_FETCHER_STATS_EN.
module tb_vram_line_fetcher;

    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [14:0]      base_addr = '0;
    logic [CNT_W-1:0] word_count = '0;
    logic             busy, done;
    logic [14:0]      vram_addr;
    logic             vram_strobe;
    logic             vram_ack;
    logic [31:0]      vram_rddata;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
`ifdef VRAM_LINE_FETCHER_STATS_EN
    logic [15:0]      stall_cycles;
`endif

    logic             arb_ack = 1'b0;
    logic [31:0]      arb_data = '0;
    logic             stray_ack = 1'b0;
    int               arb_wait = 0;

    int               checks = 0;
    int               errors = 0;

    logic [14:0]      ack_q[$];
    logic [31:0]      out_q[$];
    int               ack_total = 0, out_total = 0, max_occ = 0;
    int               done_count = 0, done_cycle = -1, last_ack_cycle = -1;
    int               cyc = 0, stall_model = 0;
    logic             strobe_seen = 1'b0;

    vram_line_fetcher #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done),
        .vram_addr(vram_addr), .vram_strobe(vram_strobe), .vram_ack(vram_ack),
        .vram_rddata(vram_rddata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef VRAM_LINE_FETCHER_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input logic [14:0] a);
        return {a ^ 15'h2A5C, 2'b10, a};
    endfunction

    // Arbiter: grants the fourth cycle a strobe has been held.
    always @(negedge clk) begin
        if (vram_strobe && arb_wait == 3) begin
            arb_ack  = 1'b1;
            arb_data = model_word(vram_addr);
            arb_wait = 0;
        end else if (vram_strobe) begin
            arb_ack  = 1'b0;
            arb_wait = arb_wait + 1;
        end else begin
            arb_ack  = 1'b0;
            arb_wait = 0;
        end
    end

    assign vram_ack    = arb_ack | stray_ack;
    assign vram_rddata = arb_ack ? arb_data : 32'hDEAD_BEEF;

    // Monitor samples just before each rising edge; occupancy reflects earlier edges.
    always @(negedge clk) begin
        #4;
        if (rst) begin
            stall_model = 0;
        end else begin
            if (ack_total - out_total > max_occ) max_occ = ack_total - out_total;
            if (busy && (ack_total - out_total) == FIFO_DEPTH) stall_model = stall_model + 1;
            if (start && !busy && !done) stall_model = 0;
            if (vram_strobe) strobe_seen = 1'b1;
            if (vram_strobe && vram_ack) begin
                ack_q.push_back(vram_addr);
                ack_total      = ack_total + 1;
                last_ack_cycle = cyc;
            end
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                out_total = out_total + 1;
            end
            if (done) begin
                done_count = done_count + 1;
                done_cycle = cyc;
            end
            cyc = cyc + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [14:0] b, input logic [CNT_W-1:0] c);
        @(negedge clk);
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic clearTrack();
        ack_q.delete();
        out_q.delete();
        ack_total   = 0;
        out_total   = 0;
        max_occ     = 0;
        done_count  = 0;
        done_cycle  = -1;
        last_ack_cycle = -1;
        strobe_seen = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (done_count == 0 && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput({tag, "_done_seen"}, 32'(done_count != 0), 32'd1);
    endtask

    task automatic checkRun(input string tag, input logic [14:0] b, input int n);
        logic [14:0] a;
        checkOutput({tag, "_acks"}, 32'(ack_total), 32'(n));
        checkOutput({tag, "_outs"}, 32'(out_total), 32'(n));
        for (int i = 0; i < n; i++) begin
            a = b + 15'(i);
            checkOutput($sformatf("%s_addr%0d", tag, i),
                        (i < ack_q.size()) ? 32'(ack_q[i]) : 32'hxxxxxxxx, 32'(a));
            checkOutput($sformatf("%s_data%0d", tag, i),
                        (i < out_q.size()) ? out_q[i] : 32'hxxxxxxxx, model_word(a));
        end
        checkOutput({tag, "_done_pulses"}, 32'(done_count), 32'd1);
        checkOutput({tag, "_done_timing"}, 32'(done_cycle), 32'(last_ack_cycle + 1));
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
        checkOutput({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;

        // Reset state
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_strobe", 32'(vram_strobe), 32'd0);
        checkOutput("rst_addr", 32'(vram_addr), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single run of 8 words
        out_ready = 1'b1;
        clearTrack();
        applyStimulus(15'h0100, 10'd8);
        checkOutput("single_busy", 32'(busy), 32'd1);
        waitDone("single", 100);
        repeat (10) @(negedge clk);
        checkRun("single", 15'h0100, 8);

        // Zero count: done next cycle, no strobe
        clearTrack();
        applyStimulus(15'h0300, 10'd0);
        checkOutput("zero_done", 32'(done), 32'd1);
        checkOutput("zero_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("zero_done_drop", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("zero_strobe", 32'(strobe_seen), 32'd0);
        checkOutput("zero_valid", 32'(out_valid), 32'd0);

        // Backpressure: FIFO fills to 16, then drains
        out_ready = 1'b0;
        clearTrack();
        applyStimulus(15'h0400, 10'd40);
        repeat (200) @(negedge clk);
        checkOutput("bp_acks_full", 32'(ack_total), 32'd16);
        checkOutput("bp_strobe_full", 32'(vram_strobe), 32'd0);
        checkOutput("bp_valid_full", 32'(out_valid), 32'd1);
        checkOutput("bp_busy_full", 32'(busy), 32'd1);
        out_ready = 1'b1;
        waitDone("bp", 400);
        repeat (10) @(negedge clk);
        checkRun("bp", 15'h0400, 40);
        checkOutput("bp_max_occ", 32'(max_occ), 32'd16);
`ifdef VRAM_LINE_FETCHER_STATS_EN
        checkOutput("bp_stall", 32'(stall_cycles), 32'(stall_model));
`endif

        // Start while busy is ignored
        clearTrack();
        applyStimulus(15'h0500, 10'd6);
        repeat (5) @(negedge clk);
        start      = 1'b1;
        base_addr  = 15'h0600;
        word_count = 10'd3;
        @(negedge clk);
        start      = 1'b0;
        waitDone("ign", 100);
        repeat (20) @(negedge clk);
        checkRun("ign", 15'h0500, 6);
`ifdef VRAM_LINE_FETCHER_STATS_EN
        checkOutput("ign_stall", 32'(stall_cycles), 32'd0);
`endif

        // Address wrap
        clearTrack();
        applyStimulus(15'h7FFE, 10'd4);
        waitDone("wrap", 100);
        repeat (10) @(negedge clk);
        checkOutput("wrap_a0", (ack_q.size() > 0) ? 32'(ack_q[0]) : 32'hxxxxxxxx, 32'h7FFE);
        checkOutput("wrap_a1", (ack_q.size() > 1) ? 32'(ack_q[1]) : 32'hxxxxxxxx, 32'h7FFF);
        checkOutput("wrap_a2", (ack_q.size() > 2) ? 32'(ack_q[2]) : 32'hxxxxxxxx, 32'h0000);
        checkOutput("wrap_a3", (ack_q.size() > 3) ? 32'(ack_q[3]) : 32'hxxxxxxxx, 32'h0001);
        checkRun("wrap", 15'h7FFE, 4);

        // Reset in the middle of a 10-word run
        out_ready = 1'b0;
        clearTrack();
        applyStimulus(15'h0700, 10'd10);
        n = 0;
        while (ack_total < 3 && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput("mid_acks", 32'(ack_total), 32'd3);
        checkOutput("mid_valid_pre", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_strobe", 32'(vram_strobe), 32'd0);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_data", out_data, 32'd0);
        repeat (2) @(negedge clk);
        clearTrack();
        rst = 1'b0;
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        checkOutput("stray_valid", 32'(out_valid), 32'd0);
        checkOutput("stray_busy", 32'(busy), 32'd0);
        checkOutput("stray_done", 32'(done), 32'd0);
`ifdef VRAM_LINE_FETCHER_STATS_EN
        checkOutput("stray_stall", 32'(stall_cycles), 32'd0);
`endif
        out_ready = 1'b1;
        clearTrack();
        applyStimulus(15'h0200, 10'd2);
        waitDone("post_rst", 100);
        repeat (10) @(negedge clk);
        checkRun("post_rst", 15'h0200, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
